// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags.
module sync_fifo #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int AFULL_THRESH  = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned        DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] LP_AFULL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] LP_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wacc;
  logic                  w_racc;
  logic [ADDR_WIDTH:0]   w_free;

  // Status comes only from registered count, so winc/rinc never reach the flags.
  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_free  = LP_DEPTH - r_count;
  assign w_wacc  = winc & ~w_full;
  assign w_racc  = rinc & ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst && w_wacc) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wacc) begin
        r_wptr <= r_wptr + LP_ONE;
      end
      if (w_racc) begin
        r_rptr  <= r_rptr + LP_ONE;
        r_rdata <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
      end
      r_rvalid <= w_racc;
      case ({w_wacc, w_racc})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
      // A new error event outranks a simultaneous clear.
      r_ovf <= (winc & w_full)  | (r_ovf & ~err_clr);
      r_udf <= (rinc & w_empty) | (r_udf & ~err_clr);
    end
  end

  assign rdata         = r_rdata;
  assign rvalid        = r_rvalid;
  assign count         = r_count;
  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign walmost_full  = (w_free <= LP_AFULL);
  assign ralmost_empty = (r_count <= LP_AEMPTY);
  assign overflow      = r_ovf;
  assign underflow     = r_udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo at default parameters (16 x 32).
module tb_sync_fifo;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid, wfull, walmost_full, rempty, ralmost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(2), .AEMPTY_THRESH(2)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .err_clr(err_clr),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .walmost_full(walmost_full),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] sb [$];
  int            m_count = 0;
  logic          m_rvalid = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic          m_wacc = 1'b0;
  logic [DW-1:0] m_rdata = '0;

  task automatic model_reset();
    sb.delete();
    m_count  = 0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  // Drives one cycle, updates the reference model, returns #1 after the edge.
  task automatic do_cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic clr);
    logic wacc, racc;
    winc = w; wdata = d; rinc = r; err_clr = clr;
    wacc  = w && (m_count != DEPTH);
    racc  = r && (m_count != 0);
    m_ovf = (w && m_count == DEPTH) || (m_ovf && !clr);
    m_udf = (r && m_count == 0) || (m_udf && !clr);
    m_rvalid = racc;
    if (racc) m_rdata = sb.pop_front();
    if (wacc) sb.push_back(d);
    m_count = sb.size();
    m_wacc  = wacc;
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset(input logic w);
    rst = 1'b1; winc = w; rinc = w; err_clr = w; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++;
    if ({count, rempty, ralmost_empty, wfull, walmost_full, rvalid, overflow, underflow} !==
        {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state count=%0d re=%b rae=%b wf=%b waf=%b rv=%b ov=%b un=%b",
               count, rempty, ralmost_empty, wfull, walmost_full, rvalid, overflow, underflow);
    end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_v [3];
    exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33;
    for (int i = 0; i < 3; i++) do_cycle(1'b1, exp_v[i], 1'b0, 1'b0);
    checks++;
    if (count !== 5'd3 || ralmost_empty !== 1'b0) begin
      errors++; $display("FAIL basic_fill count=%0d rae=%b exp 3/0", count, ralmost_empty);
    end
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_v[i] || rdata !== m_rdata) begin
        errors++; $display("FAIL basic_read%0d rv=%b rdata=%h exp=%h", i, rvalid, rdata, exp_v[i]);
      end
      checks++;
      if (ralmost_empty !== 1'b1) begin
        errors++; $display("FAIL basic_aempty%0d got=%b exp=1", i, ralmost_empty);
      end
    end
    checks++;
    if (rempty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL basic_empty rempty=%b count=%0d exp 1/0", rempty, count);
    end
    do_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h33) begin
      errors++; $display("FAIL basic_hold rv=%b rdata=%h exp 0/00000033", rvalid, rdata);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b1, 32'h100 + i, 1'b0, 1'b0);
      checks++;
      if (count !== 5'(i + 1) || wfull !== (i + 1 == DEPTH) || walmost_full !== (i + 1 >= 14) ||
          ralmost_empty !== (i + 1 <= 2) || rempty !== 1'b0) begin
        errors++;
        $display("FAIL fill%0d count=%0d wf=%b waf=%b rae=%b re=%b", i, count, wfull,
                 walmost_full, ralmost_empty, rempty);
      end
    end
    do_cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || wfull !== 1'b1 || overflow !== m_ovf) begin
      errors++; $display("FAIL overflow ov=%b count=%0d wf=%b exp 1/16/1", overflow, count, wfull);
    end
  endtask

  task automatic test_full_rw();
    do_cycle(1'b1, 32'hBEEF, 1'b1, 1'b0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h100 || count !== 5'd15 || overflow !== 1'b1 || wfull !== 1'b0) begin
      errors++;
      $display("FAIL full_rw rv=%b rdata=%h count=%0d ov=%b wf=%b exp 1/00000100/15/1/0",
               rvalid, rdata, count, overflow, wfull);
    end
    for (int k = 0; k < 15; k++) begin
      do_cycle(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h101 + k || rdata !== m_rdata) begin
        errors++; $display("FAIL drain%0d rv=%b rdata=%h exp=%h", k, rvalid, rdata, 32'h101 + k);
      end
    end
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0 || count !== 5'd0 || rempty !== 1'b1) begin
      errors++; $display("FAIL ovf_clear ov=%b count=%0d re=%b exp 0/0/1", overflow, count, rempty);
    end
  endtask

  task automatic test_empty_rw();
    do_cycle(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (underflow !== 1'b1 || rvalid !== 1'b0) begin
      errors++; $display("FAIL udf_set_vs_clr un=%b rv=%b exp 1/0", underflow, rvalid);
    end
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear un=%b exp 0", underflow); end
    do_cycle(1'b1, 32'hA5, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || rvalid !== 1'b0 || rempty !== 1'b0) begin
      errors++; $display("FAIL empty_rw count=%0d un=%b rv=%b re=%b exp 1/1/0/0", count, underflow, rvalid, rempty);
    end
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (underflow !== 1'b0 || count !== 5'd1) begin
      errors++; $display("FAIL errclr_keeps_count un=%b count=%0d exp 0/1", underflow, count);
    end
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA5 || rdata !== m_rdata) begin
      errors++; $display("FAIL empty_rw_read rv=%b rdata=%h exp 1/000000a5", rvalid, rdata);
    end
  endtask

  task automatic test_stream();
    int   nxt = 0;
    int   got = 0;
    int   cyc = 0;
    logic w, r;
    while ((nxt < 40 || m_count != 0) && cyc < 2000) begin
      w = (nxt < 40) && ($urandom_range(0, 99) < 55);
      r = (nxt >= 40) || ($urandom_range(0, 99) < 45);
      do_cycle(w, 32'h1000 + nxt, r, 1'b0);
      if (m_wacc) nxt++;
      checks++;
      if (count !== 5'(m_count) || rvalid !== m_rvalid) begin
        errors++; $display("FAIL stream_cnt cyc=%0d count=%0d rv=%b exp %0d/%b", cyc, count, rvalid, m_count, m_rvalid);
      end
      if (m_rvalid) begin
        checks++;
        if (rdata !== 32'h1000 + got) begin
          errors++; $display("FAIL stream_order cyc=%0d rdata=%h exp=%h", cyc, rdata, 32'h1000 + got);
        end
        got++;
      end
      cyc++;
    end
    checks++;
    if (cyc >= 2000 || got != 40) begin
      errors++; $display("FAIL stream_done reads=%0d exp=40 cycles=%0d", got, cyc);
    end
  endtask

  task automatic test_reset_midop();
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 32'h200 + i, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd5 || underflow !== 1'b1) begin
      errors++; $display("FAIL midop_pre count=%0d un=%b exp 5/1", count, underflow);
    end
    rst = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 32'h777;
    @(posedge clk); #1;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    model_reset();
    checks++;
    if ({count, rempty, ralmost_empty, wfull, walmost_full, rvalid, overflow, underflow} !==
        {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0} || rdata !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset count=%0d re=%b rae=%b rv=%b ov=%b un=%b rdata=%h",
               count, rempty, ralmost_empty, rvalid, overflow, underflow, rdata);
    end
    do_cycle(1'b1, 32'h55, 1'b0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h55 || count !== 5'd0) begin
      errors++; $display("FAIL post_reset_rd rv=%b rdata=%h count=%0d exp 1/00000055/0", rvalid, rdata, count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_rw();
    test_empty_rw();
    test_stream();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, log2 of storage depth; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 32, entry width in bits.
REQ-003 Parameter AFULL_THRESH, default 2, free-entry count at or below which walmost_full asserts; legal range 1..DEPTH-1.
REQ-004 Parameter AEMPTY_THRESH, default 2, occupancy at or below which ralmost_empty asserts; legal range 1..DEPTH-1.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 winc  input  1  write request.
REQ-008 wdata  input  DATA_WIDTH  write data, sampled with winc.
REQ-009 rinc  input  1  read request.
REQ-010 err_clr  input  1  clears sticky error flags.
REQ-011 rdata  output  DATA_WIDTH  registered read data.
REQ-012 rvalid  output  1  rdata holds a newly popped entry this cycle.
REQ-013 wfull  output  1  occupancy == DEPTH.
REQ-014 walmost_full  output  1  (DEPTH - occupancy) <= AFULL_THRESH.
REQ-015 rempty  output  1  occupancy == 0.
REQ-016 ralmost_empty  output  1  occupancy <= AEMPTY_THRESH.
REQ-017 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-018 overflow  output  1  sticky: write attempted while full.
REQ-019 underflow  output  1  sticky: read attempted while empty.

Function
REQ-020 Storage SHALL be a DEPTH x DATA_WIDTH array written on clk, indexed by the low ADDR_WIDTH bits of the write pointer.
REQ-021 Write and read pointers SHALL be ADDR_WIDTH+1 bits; the MSB is a wrap bit; pointers increment modulo 2**(ADDR_WIDTH+1).
REQ-022 Write accepted iff winc && !wfull, evaluated on pre-edge state; accepted write stores wdata at wptr and increments wptr.
REQ-023 Read accepted iff rinc && !rempty, evaluated on pre-edge state; accepted read loads mem[rptr] into rdata at that edge and increments rptr.
REQ-024 Read latency: rdata and rvalid=1 appear the cycle after the accepting edge; rvalid=0 in any cycle following no accepted read; rdata holds its last value when no read is accepted.
REQ-025 count SHALL update at the edge: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-026 wfull, walmost_full, rempty, ralmost_empty SHALL be derived from registered count/pointers (no combinational path from winc/rinc).
REQ-027 Full with winc && rinc: read accepted, write dropped, overflow set, count becomes DEPTH-1.
REQ-028 Empty with winc && rinc: write accepted, read rejected (no read-through), underflow set, rvalid=0 next cycle, count becomes 1.
REQ-029 Non-full, non-empty with winc && rinc: both accepted, count unchanged.
REQ-030 overflow SHALL set on winc && wfull, underflow on rinc && rempty; both hold until err_clr or rst; a set event coincident with err_clr SHALL leave the flag set.
REQ-031 Pointer wrap SHALL be transparent: data order preserved across any number of wraps.
REQ-032 Behaviour with parameter values outside stated ranges is undefined.

Reset
REQ-033 rst SHALL take priority over winc, rinc, err_clr in the same cycle.
REQ-034 After a cycle with rst=1: wptr=rptr=0, count=0, rempty=1, ralmost_empty=1, wfull=0, walmost_full=0, rvalid=0, rdata=0, overflow=0, underflow=0.
REQ-035 Storage contents need not be cleared; reset mid-operation discards all held entries.

Verification
REQ-036 Reset, then write 0x11,0x22,0x33, then read 3 times -> rdata 0x11,0x22,0x33 each one cycle after its accepting edge with rvalid=1; rempty=1 after.
REQ-037 Defaults: write 16 entries -> wfull=1 and count=16 after 16th edge; walmost_full=1 from count=14; 17th winc -> overflow=1, count stays 16.
REQ-038 Full FIFO, winc&&rinc one cycle -> oldest entry read out, new data dropped, count=15, overflow=1.
REQ-039 Empty FIFO, winc&&rinc with wdata=0xA5 -> count=1, underflow=1, rvalid=0; next read returns 0xA5.
REQ-040 Stream 40 entries (incrementing) with random winc/rinc -> output order exact across pointer wraps; count always equals writes minus reads.
REQ-041 Assert rst with count=5 and winc=1 -> next cycle count=0, rempty=1, flags cleared; err_clr alone clears overflow/underflow without touching count.
